byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Consumer stage after the 4-byte framing counter in the packet switcher datapath.
- Accepts a byte stream with start-of-packet marking and packs every 4 accepted bytes into one 32-bit word.
- Each word is tagged with the packet's destination port.
- Words are buffered in a small output FIFO with a valid/ready interface toward the switch fabric.

Parameters:
- BYTE_W, 8: width of one input byte.
- DEST_W, 2: destination field width, taken from the LSBs of the SOP byte.
- DEPTH, 2: output FIFO depth in words; power of 2, minimum 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data/in_sop valid.
- in_data  input  BYTE_W  byte payload.
- in_sop  input  1  first byte of a packet (header byte).
- in_ready  output  1  packer can accept a byte this cycle.
- out_valid  output  1  FIFO head word valid.
- out_data  output  4*BYTE_W  packed word; first byte in MSBs.
- out_dest  output  DEST_W  destination tag of head word.
- out_ready  input  1  downstream consumes head word.
- misalign  output  1  sticky: SOP arrived with a partial word pending.
- overflow  output  1  sticky: in_valid while in_ready low.

Behaviour:
- Byte accept = in_valid & in_ready. Word pop = out_valid & out_ready.
- lane: 2-bit register, 0..3, advances by 1 per accept and wraps 3->0. Accepted byte is written to out-word slot [(3-lane)*BYTE_W +: BYTE_W].
- Accept with lane==3 completes the word. On that same edge, {word, dest} is pushed into the FIFO and lane returns to 0.
- Latency: out_valid is high the cycle after the edge that accepted the 4th byte, provided the FIFO was empty.
- in_ready = !(lane==3 && fifo_count==DEPTH). It is registered-state only, with no combinational path from out_ready. Bytes 0..2 are accepted even when the FIFO is full.
- Simultaneous push and pop with the FIFO full cannot occur (in_ready is low). Simultaneous push and pop otherwise: fifo_count is unchanged and ordering is preserved.
- SOP handling:
  - Accept with in_sop=1 latches dest_reg <= in_data[DEST_W-1:0]. The SOP byte is also payload (lane-0 slot).
  - If lane!=0 at SOP: the partial word is discarded, the SOP byte is placed in slot 0, lane becomes 1, and misalign is set.
  - A non-SOP byte is tagged with the current dest_reg. Bytes before the first SOP after reset use dest 0.
- FIFO: circular buffer with read/write pointers and count 0..DEPTH. out_data/out_dest come from the head entry and are stable while out_valid=1 && out_ready=0.
- Sticky flags: misalign and overflow clear only on reset. Overflow also covers in_valid while in_ready=0 (the byte is dropped and no state changes).
- Reset (including mid-word or mid-packet): lane=0, dest_reg=0, FIFO emptied, out_valid=0, out_data=0, out_dest=0, misalign=0, overflow=0. in_ready=1 the cycle after reset deasserts. Partial words are lost.
- Outputs with an empty FIFO: out_valid=0; out_data/out_dest are don't-care but must not be X after reset.

Optional Feature:
- Macro PACKER_PARITY_EN.
- Defined:
  - Adds input in_parity (1 bit, even parity over in_data) and output out_perr (1 bit).
  - A per-word error bit accumulates the OR of parity mismatches over its 4 bytes. It is stored in the FIFO alongside the word and presented as out_perr with out_data.
  - The error bit is cleared on word completion, on SOP restart, and on reset.
- Undefined: neither port exists, no parity logic; behaviour is otherwise identical.

Test Plan:
- Reset, then SOP byte 0x02 followed by 0x11,0x22,0x33 with out_ready=1 -> one cycle after 4th accept, out_valid=1, out_data=0x02112233, out_dest=2; popped next edge.
- 12 bytes 0x00..0x0B with SOP on the first byte, out_ready=0 -> 2 words buffered. in_ready drops while lane==3 with the FIFO full (byte 0x0B stalled). Raise out_ready -> words 0x00010203, 0x04050607, 0x08090A0B in order.
- Bytes 0xA1,0xA2 then SOP 0x03,0xB1,0xB2,0xB3 -> misalign=1; only word 0x03B1B2B3 with dest 3 emerges.
- Drive in_valid during a stall -> overflow=1 and stays 1; the next word after the stall clears is intact.
- Assert reset after 2 bytes of a word with 1 word in the FIFO -> next cycle out_valid=0, in_ready=1, flags 0; a new 4-byte word emerges correctly.
- (PACKER_PARITY_EN) bad parity on the 3rd byte of word 1 only -> out_perr=1 for word 1, 0 for word 2.

Source files
------------

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for byte_word_packer.
// PACKER_PARITY_EN adds in_parity / out_perr.
interface byte_word_packer_if #(
    parameter int BYTE_W = 8,
    parameter int DEST_W = 2
);
    logic                  in_valid;
    logic [BYTE_W-1:0]     in_data;
    logic                  in_sop;
    logic                  in_ready;
    logic                  out_valid;
    logic [4*BYTE_W-1:0]   out_data;
    logic [DEST_W-1:0]     out_dest;
    logic                  out_ready;
    logic                  misalign;
    logic                  overflow;
`ifdef PACKER_PARITY_EN
    logic                  in_parity;
    logic                  out_perr;
`endif

    modport slave (
        input  in_valid, in_data, in_sop, out_ready,
        output in_ready, out_valid, out_data, out_dest, misalign, overflow
`ifdef PACKER_PARITY_EN
        , input in_parity
        , output out_perr
`endif
    );

    modport master (
        output in_valid, in_data, in_sop, out_ready,
        input  in_ready, out_valid, out_data, out_dest, misalign, overflow
`ifdef PACKER_PARITY_EN
        , output in_parity
        , input out_perr
`endif
    );
endinterface

// File: rtl/byte_word_packer.sv
// Packs 4 accepted bytes (first byte in MSBs) into a dest-tagged word and queues it in a small FIFO.
// Optional per-word parity error tracking under `define PACKER_PARITY_EN.
module byte_word_packer #(
    parameter int BYTE_W = 8,
    parameter int DEST_W = 2,
    parameter int DEPTH  = 2
) (
    input logic              clock,
    input logic              reset,
    byte_word_packer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = 4 * BYTE_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]        r_lane;
    logic [WW-1:0]     r_word;
    logic [DEST_W-1:0] r_dest;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [WW-1:0]     r_mem      [DEPTH];
    logic [DEST_W-1:0] r_mem_dest [DEPTH];
    logic              r_misalign, r_overflow;

    logic              w_ready, w_accept, w_pop, w_push;
    logic [WW-1:0]     w_word_next;

    // Ready depends on registered state only, so no out_ready -> in_ready path.
    assign w_ready  = !(r_lane == 2'd3 && r_count == FULL);
    assign w_accept = bus.in_valid && w_ready;
    assign w_pop    = (r_count != '0) && bus.out_ready;
    assign w_push   = w_accept && !bus.in_sop && r_lane == 2'd3;

    always_comb begin
        w_word_next = r_word;
        for (int k = 0; k < 4; k++)
            if (r_lane == 2'(3 - k)) w_word_next[k*BYTE_W +: BYTE_W] = bus.in_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lane     <= '0;
            r_word     <= '0;
            r_dest     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_overflow <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k]      <= '0;
                r_mem_dest[k] <= '0;
            end
        end else begin
            if (bus.in_valid && !w_ready) r_overflow <= 1'b1;
            if (w_accept) begin
                if (bus.in_sop) begin
                    // SOP restarts the word; any pending partial is dropped.
                    r_dest <= bus.in_data[DEST_W-1:0];
                    r_word <= {bus.in_data, {(3*BYTE_W){1'b0}}};
                    r_lane <= 2'd1;
                    if (r_lane != 2'd0) r_misalign <= 1'b1;
                end else begin
                    r_word <= w_word_next;
                    r_lane <= r_lane + 2'd1;
                end
            end
            if (w_push) begin
                r_mem[r_wptr]      <= w_word_next;
                r_mem_dest[r_wptr] <= r_dest;
                r_wptr             <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rptr];
    assign bus.out_dest  = r_mem_dest[r_rptr];
    assign bus.misalign  = r_misalign;
    assign bus.overflow  = r_overflow;

`ifdef PACKER_PARITY_EN
    logic w_perr_byte;
    logic r_perr_acc;
    logic r_mem_perr [DEPTH];

    assign w_perr_byte = (^bus.in_data) ^ bus.in_parity;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perr_acc <= 1'b0;
            for (int k = 0; k < DEPTH; k++) r_mem_perr[k] <= 1'b0;
        end else begin
            if (w_accept) begin
                if (bus.in_sop)  r_perr_acc <= w_perr_byte;
                else if (w_push) r_perr_acc <= 1'b0;
                else             r_perr_acc <= r_perr_acc | w_perr_byte;
            end
            if (w_push) r_mem_perr[r_wptr] <= r_perr_acc | w_perr_byte;
        end
    end

    assign bus.out_perr = r_mem_perr[r_rptr];
`endif
endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic vs a queue-based model.
module tb_byte_word_packer;
    localparam int BYTE_W = 8;
    localparam int DEST_W = 2;
    localparam int DEPTH  = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    byte_word_packer_if #(.BYTE_W(BYTE_W), .DEST_W(DEST_W)) bus();
    byte_word_packer #(.BYTE_W(BYTE_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: list of pending bytes and a queue of finished words.
    typedef struct { logic [31:0] w; logic [1:0] d; logic e; } ent_t;
    ent_t        mq[$];
    logic [7:0]  mpart[$];
    logic        mpe;
    logic [1:0]  mdest;
    logic        mmis, movf;

    function automatic bit m_ready();
        return !(mpart.size() == 3 && mq.size() == DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit sop, input logic [7:0] d,
                        input bit ordy, input bit pbad);
        bit   acc;
        ent_t e;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_sop    = sop;
        bus.in_data   = d;
        bus.out_ready = ordy;
`ifdef PACKER_PARITY_EN
        bus.in_parity = (^d) ^ pbad;
`endif
        if (rst) begin
            mq.delete(); mpart.delete();
            mpe = 0; mdest = 0; mmis = 0; movf = 0;
        end else begin
            acc = v && m_ready();
            if (v && !acc) movf = 1;
            if (mq.size() != 0 && ordy) mq.delete(0);
            if (acc) begin
                if (sop) begin
                    if (mpart.size() != 0) mmis = 1;
                    mpart.delete();
                    mpe   = 0;
                    mdest = d[1:0];
                end
                mpart.push_back(d);
                mpe = mpe | pbad;
                if (mpart.size() == 4) begin
                    e.w = {mpart[0], mpart[1], mpart[2], mpart[3]};
                    e.d = mdest;
                    e.e = mpe;
                    mq.push_back(e);
                    mpart.delete();
                    mpe = 0;
                end
            end
        end
        @(posedge clock);
        #1;
        chk("m_valid", bus.out_valid, mq.size() != 0);
        chk("m_in_ready", bus.in_ready, m_ready());
        chk("m_misalign", bus.misalign, mmis);
        chk("m_overflow", bus.overflow, movf);
        if (mq.size() != 0) begin
            chk("m_data", bus.out_data, mq[0].w);
            chk("m_dest", bus.out_dest, mq[0].d);
`ifdef PACKER_PARITY_EN
            chk("m_perr", bus.out_perr, mq[0].e);
`endif
        end
    endtask

    typedef struct {
        bit v; bit sop; logic [7:0] d; bit ordy;
        bit e_valid; logic [31:0] e_data; logic [1:0] e_dest; bit e_ready;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{1, 1, 8'h02, 1, 0, 32'h0,        2'd0, 1};
        tbl[1] = '{1, 0, 8'h11, 1, 0, 32'h0,        2'd0, 1};
        tbl[2] = '{1, 0, 8'h22, 1, 0, 32'h0,        2'd0, 1};
        tbl[3] = '{1, 0, 8'h33, 1, 1, 32'h02112233, 2'd2, 1};
        tbl[4] = '{0, 0, 8'h00, 1, 0, 32'h0,        2'd0, 1};

        // Reset state
        step(1, 0, 0, 8'h00, 0, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_data", bus.out_data, 0);
        chk("rst_dest", bus.out_dest, 0);

        // Basic word, table-driven
        for (int i = 0; i < 5; i++) begin
            step(0, tbl[i].v, tbl[i].sop, tbl[i].d, tbl[i].ordy, 0);
            chk("tbl_valid", bus.out_valid, tbl[i].e_valid);
            chk("tbl_ready", bus.in_ready, tbl[i].e_ready);
            if (tbl[i].e_valid) begin
                chk("tbl_data", bus.out_data, tbl[i].e_data);
                chk("tbl_dest", bus.out_dest, tbl[i].e_dest);
            end
        end

        // FIFO full: 11 bytes buffered, 12th stalled until a pop
        step(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, i == 0, 8'(i), 0, 0);
        chk("full_ready", bus.in_ready, 0);
        chk("full_head", bus.out_data, 32'h00010203);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("full_ready_after_pop", bus.in_ready, 1);
        chk("full_head1", bus.out_data, 32'h04050607);
        step(0, 1, 0, 8'h0B, 1, 0);
        chk("full_head2", bus.out_data, 32'h08090A0B);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("full_drained", bus.out_valid, 0);
        chk("full_no_ovf", bus.overflow, 0);

        // Misaligned SOP
        step(1, 0, 0, 8'h00, 0, 0);
        step(0, 1, 0, 8'hA1, 0, 0);
        step(0, 1, 0, 8'hA2, 0, 0);
        step(0, 1, 1, 8'h03, 0, 0);
        chk("mis_flag", bus.misalign, 1);
        step(0, 1, 0, 8'hB1, 0, 0);
        step(0, 1, 0, 8'hB2, 0, 0);
        step(0, 1, 0, 8'hB3, 0, 0);
        chk("mis_data", bus.out_data, 32'h03B1B2B3);
        chk("mis_dest", bus.out_dest, 3);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("mis_one_word", bus.out_valid, 0);

        // Overflow during stall
        step(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, i == 0, 8'(8'h10 + i), 0, 0);
        step(0, 1, 0, 8'h55, 0, 0);
        chk("ovf_flag", bus.overflow, 1);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("ovf_head1", bus.out_data, 32'h14151617);
        step(0, 1, 0, 8'h77, 1, 0);
        chk("ovf_intact", bus.out_data, 32'h18191A77);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("ovf_sticky", bus.overflow, 1);

        // Reset mid-word with a word queued and misalign set
        step(1, 0, 0, 8'h00, 0, 0);
        step(0, 1, 1, 8'h01, 0, 0);
        step(0, 1, 0, 8'h02, 0, 0);
        step(0, 1, 0, 8'h03, 0, 0);
        step(0, 1, 0, 8'h04, 0, 0);
        step(0, 1, 0, 8'h05, 0, 0);
        step(0, 1, 1, 8'h09, 0, 0);
        step(0, 1, 0, 8'h0A, 0, 0);
        chk("pre_rst_mis", bus.misalign, 1);
        step(1, 0, 0, 8'h00, 0, 0);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_ready", bus.in_ready, 1);
        chk("mrst_mis", bus.misalign, 0);
        chk("mrst_ovf", bus.overflow, 0);
        step(0, 1, 1, 8'hC1, 0, 0);
        step(0, 1, 0, 8'hC2, 0, 0);
        step(0, 1, 0, 8'hC3, 0, 0);
        step(0, 1, 0, 8'hC4, 0, 0);
        chk("mrst_word", bus.out_data, 32'hC1C2C3C4);
        chk("mrst_dest", bus.out_dest, 1);

`ifdef PACKER_PARITY_EN
        step(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, i == 0, 8'(8'h40 + i), 0, i == 2);
        chk("perr_w1", bus.out_perr, 1);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("perr_w2", bus.out_perr, 0);
`endif

        // Random traffic against the model
        step(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
                 8'($urandom), ($urandom % 2) != 0, ($urandom % 8) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
